nnet_argmax_rx: RTL and testbench



---
 rtl/nnet_argmax_rx.sv | 122 ++++++++++++
 tb/tb_nnet_argmax_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nnet_argmax_rx.sv
// Argmax post-processor for the HLS score stream: regenerates vector framing from
// const_size_out and emits one {index, max score} word per vector.
module nnet_argmax_rx #(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned IDX_W   = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [15:0] const_size_out,
    input  logic [31:0] res_V_V_TDATA,
    input  logic        res_V_V_TVALID,
    output logic        res_V_V_TREADY,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [31:0] vec_count,
    output logic        rx_busy
);
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned CNT_P1_W   = CNT_W + 1;
    localparam int unsigned OUT_HALF_W = 16;
    localparam int unsigned DATA_W     = 32;

    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]          size_q, size_d;
    logic signed [SCORE_W-1:0] best_score_q, best_score_d;
    logic [IDX_W-1:0]          best_idx_q, best_idx_d;
    logic [DATA_W-1:0]         o_tdata_q, o_tdata_d;
    logic [DATA_W-1:0]         vec_count_q, vec_count_d;
    logic                      o_tvalid_q, o_tvalid_d;
    logic                      rx_busy_q, rx_busy_d;

    logic signed [SCORE_W-1:0] beat_score;
    logic signed [SCORE_W-1:0] cand_score;
    logic [IDX_W-1:0]          cand_idx;
    logic [CNT_W-1:0]          first_size;
    logic                      first_beat;
    logic                      last_beat;
    logic                      better;
    logic                      beat_acc;
    logic                      unused_tdata_hi;

    assign unused_tdata_hi = ^res_V_V_TDATA[DATA_W-1:SCORE_W];

    // Beat classification: the vector length is sampled only on the first beat.
    always_comb begin
        beat_score = $signed(res_V_V_TDATA[SCORE_W-1:0]);
        first_beat = (cnt_q == '0);
        first_size = (const_size_out == '0) ? CNT_W'(1) : const_size_out;
        last_beat  = first_beat ? (first_size == CNT_W'(1))
                                : ((CNT_P1_W'(cnt_q) + CNT_P1_W'(1)) == CNT_P1_W'(size_q));
        better     = !first_beat && (beat_score > best_score_q);
        cand_score = (first_beat || better) ? beat_score : best_score_q;
        cand_idx   = first_beat ? '0 : (better ? IDX_W'(cnt_q) : best_idx_q);
    end

    // Only a last beat needs the output slot, so only it can stall.
    assign res_V_V_TREADY = !(last_beat && o_tvalid_q && !o_tready);
    assign beat_acc       = res_V_V_TVALID && res_V_V_TREADY;

    always_comb begin
        cnt_d        = cnt_q;
        size_d       = size_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        o_tdata_d    = o_tdata_q;
        vec_count_d  = vec_count_q;
        o_tvalid_d   = o_tvalid_q;

        if (o_tready) begin
            o_tvalid_d = 1'b0;
        end

        if (beat_acc) begin
            best_score_d = cand_score;
            best_idx_d   = cand_idx;
            if (first_beat) begin
                size_d = first_size;
            end
            if (last_beat) begin
                cnt_d       = '0;
                vec_count_d = vec_count_q + DATA_W'(1);
                o_tvalid_d  = 1'b1;
                o_tdata_d   = {OUT_HALF_W'(cand_idx), OUT_HALF_W'(cand_score)};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        rx_busy_d = (cnt_d != '0);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q        <= '0;
            size_q       <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            o_tdata_q    <= '0;
            vec_count_q  <= '0;
            o_tvalid_q   <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            o_tdata_q    <= o_tdata_d;
            vec_count_q  <= vec_count_d;
            o_tvalid_q   <= o_tvalid_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign o_tdata   = o_tdata_q;
    assign o_tvalid  = o_tvalid_q;
    assign o_tlast   = o_tvalid_q;
    assign vec_count = vec_count_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_nnet_argmax_rx.sv
// Directed bench for nnet_argmax_rx: framing, signed argmax, back-pressure, size edges, reset.
module tb_nnet_argmax_rx;

    logic        clk;
    logic        rst_n;
    logic [15:0] size;
    logic [31:0] tdata;
    logic        tvalid;
    logic        s_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [31:0] vec_count;
    logic        rx_busy;

    int tests = 0;
    int fails = 0;

    nnet_argmax_rx dut (
        .ap_clk         (clk),
        .ap_rst_n       (rst_n),
        .const_size_out (size),
        .res_V_V_TDATA  (tdata),
        .res_V_V_TVALID (tvalid),
        .res_V_V_TREADY (s_tready),
        .o_tdata        (o_tdata),
        .o_tlast        (o_tlast),
        .o_tvalid       (o_tvalid),
        .o_tready       (o_tready),
        .vec_count      (vec_count),
        .rx_busy        (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one beat per cycle; callers keep o_tready high so no beat stalls.
    task automatic drive_beats(input logic [15:0] sc[$]);
        foreach (sc[i]) begin
            tdata  = {16'hA5A5, sc[i]};
            tvalid = 1'b1;
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tdata  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; size = 16'd4; tvalid = 1'b0; tdata = '0; o_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b expected 0", o_tvalid); end
        tests++; if (o_tdata !== 32'h0) begin fails++; $display("FAIL rst_tdata: got %h expected 00000000", o_tdata); end
        tests++; if (o_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b expected 0", o_tlast); end
        tests++; if (vec_count !== 32'h0) begin fails++; $display("FAIL rst_vec_count: got %0d expected 0", vec_count); end
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_tready: got %b expected 1", s_tready); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", rx_busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (s_tready !== 1'b1 || o_tvalid !== 1'b0) begin
            fails++; $display("FAIL post_rst: got tready=%b tvalid=%b expected 1 0", s_tready, o_tvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_max();
        logic [15:0] sc [4];
        sc = '{16'd5, 16'hFFFD, 16'd17, 16'd2};
        size = 16'd4;
        for (int i = 0; i < 4; i++) begin
            tdata  = {16'hDEAD, sc[i]};
            tvalid = 1'b1;
            @(negedge clk);
            tests++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: beat %0d got %b expected 0", i, o_tvalid); end
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b expected 1", o_tvalid); end
        tests++; if (o_tdata !== 32'h0002_0011) begin fails++; $display("FAIL basic_data: got %h expected 00020011", o_tdata); end
        tests++; if (o_tlast !== 1'b1) begin fails++; $display("FAIL basic_tlast: got %b expected 1", o_tlast); end
        tests++; if (vec_count !== 32'd1) begin fails++; $display("FAIL basic_vec_count: got %0d expected 1", vec_count); end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b expected 0", rx_busy); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL basic_pop: got %b expected 0", o_tvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_signed_tie();
        logic [15:0] sc [$];
        sc = '{16'hFFF8, 16'hFFFE, 16'hFFFE, 16'hFFF7, 16'hFFFE};
        size = 16'd5;
        tdata = {16'h1234, sc[0]}; tvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0;
        @(negedge clk);
        tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL signed_busy: got %b expected 1", rx_busy); end
        sc.delete(0);
        drive_beats(sc);
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b1 || o_tdata !== 32'h0001_FFFE) begin
            fails++; $display("FAIL signed_tie: got v=%b %h expected v=1 0001fffe", o_tvalid, o_tdata);
        end
        tests++; if (vec_count !== 32'd2) begin fails++; $display("FAIL signed_vec_count: got %0d expected 2", vec_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        logic [15:0] sc [6];
        logic [31:0] exp_w [3];
        logic [31:0] got [$];
        logic [31:0] vc0;
        int bi;
        bit stalled;
        sc    = '{16'd1, 16'd9, 16'd7, 16'd3, 16'hFFFF, 16'hFFFF};
        exp_w = '{32'h0001_0009, 32'h0000_0007, 32'h0000_FFFF};
        vc0 = vec_count; size = 16'd2; bi = 0; stalled = 1'b0;
        for (int c = 0; c < 30; c++) begin
            o_tready = (c >= 10);
            if (bi < 6) begin
                tvalid = 1'b1; tdata = {16'h5A5A, sc[bi]};
            end else begin
                tvalid = 1'b0; tdata = '0;
            end
            @(negedge clk);
            if (tvalid && !s_tready) begin
                stalled = 1'b1;
                tests++; if (bi != 3) begin fails++; $display("FAIL bp_stall_beat: got beat %0d expected 3", bi); end
            end
            if (o_tvalid && !o_tready) begin
                tests++; if (o_tdata !== 32'h0001_0009 || o_tlast !== 1'b1) begin
                    fails++; $display("FAIL bp_hold: cycle %0d got %h last=%b expected 00010009 last=1", c, o_tdata, o_tlast);
                end
            end
            if (o_tvalid && o_tready) got.push_back(o_tdata);
            if (tvalid && s_tready) bi++;
            @(posedge clk); #1;
        end
        tvalid = 1'b0; o_tready = 1'b1;
        tests++; if (stalled !== 1'b1) begin fails++; $display("FAIL bp_stalled: got %b expected 1", stalled); end
        tests++; if (got.size() != 3) begin fails++; $display("FAIL bp_count: got %0d words expected 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                tests++; if (got[i] !== exp_w[i]) begin fails++; $display("FAIL bp_word%0d: got %h expected %h", i, got[i], exp_w[i]); end
            end
        end
        tests++; if (vec_count - vc0 !== 32'd3) begin fails++; $display("FAIL bp_vec_count: got %0d expected 3", vec_count - vc0); end
    endtask

    task automatic test_size_edges();
        o_tready = 1'b1;
        size = 16'd0; tdata = {16'hFFFF, 16'd42}; tvalid = 1'b1;
        @(posedge clk); #1;
        size = 16'd1; tdata = {16'h0000, 16'hFFFB};
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b1 || o_tdata !== 32'h0000_002A) begin
            fails++; $display("FAIL size0: got v=%b %h expected v=1 0000002a", o_tvalid, o_tdata);
        end
        tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL size_b2b_ready: got %b expected 1", s_tready); end
        @(posedge clk); #1;
        tvalid = 1'b0;
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b1 || o_tdata !== 32'h0000_FFFB) begin
            fails++; $display("FAIL size1: got v=%b %h expected v=1 0000fffb", o_tvalid, o_tdata);
        end
        @(posedge clk); #1;
        size = 16'd3; tdata = {16'h0, 16'd4}; tvalid = 1'b1;
        @(posedge clk); #1;
        size = 16'd6; tdata = {16'h0, 16'd8};
        @(posedge clk); #1;
        tdata = {16'h0, 16'd2};
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b0) begin fails++; $display("FAIL size_chg_early: got %b expected 0", o_tvalid); end
        @(posedge clk); #1;
        tvalid = 1'b0;
        @(negedge clk);
        tests++; if (o_tvalid !== 1'b1 || o_tdata !== 32'h0001_0008) begin
            fails++; $display("FAIL size_chg: got v=%b %h expected v=1 00010008", o_tvalid, o_tdata);
        end
        tests++; if (rx_busy !== 1'b0) begin fails++; $display("FAIL size_chg_busy: got %b expected 0", rx_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_vector();
        logic [15:0] sc [$];
        int n_out;
        o_tready = 1'b1; size = 16'd8;
        sc = '{16'd50, 16'd60, 16'd70};
        drive_beats(sc);
        @(negedge clk);
        tests++; if (rx_busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %b expected 1", rx_busy); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (rx_busy !== 1'b0 || o_tvalid !== 1'b0 || vec_count !== 32'd0) begin
            fails++; $display("FAIL mid_rst: got busy=%b v=%b cnt=%0d expected 0 0 0", rx_busy, o_tvalid, vec_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sc = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd100, 16'd7};
        n_out = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                tvalid = 1'b1; tdata = {16'h0, sc[i]};
            end else begin
                tvalid = 1'b0; tdata = '0;
            end
            @(negedge clk);
            if (o_tvalid) begin
                n_out++;
                tests++; if (o_tdata !== 32'h0006_0064) begin fails++; $display("FAIL mid_word: got %h expected 00060064", o_tdata); end
            end
            @(posedge clk); #1;
        end
        tests++; if (n_out != 1) begin fails++; $display("FAIL mid_count: got %0d words expected 1", n_out); end
        tests++; if (vec_count !== 32'd1) begin fails++; $display("FAIL mid_vec_count: got %0d expected 1", vec_count); end
    endtask

    initial begin
        test_reset();
        test_basic_max();
        test_signed_tie();
        test_back_pressure();
        test_size_edges();
        test_reset_mid_vector();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
